// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encodings and port IDs.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/dmem_arbiter_pick.sv
// Winner select between the CPU and debug ports, plus the arbitration history register.
// Latency: combinational winner; history updates on the clock edge that makes a grant.
// Backpressure: none; only the top decides when a grant is taken (i_grant).
//
// Ports: i_req0/i_req1 requests, i_grant = a grant is taken this cycle, o_winner = chosen port.
// Optional macro DMEM_ARB_RR_EN: round-robin instead of fixed priority with starvation guard.
module dmem_arbiter_pick
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
)(
    input  logic clk,
    input  logic rst_n,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_grant,
    output logic o_winner
);

`ifdef DMEM_ARB_RR_EN

    // r_ptr names the port that wins the next tie; it moves away from each winner.
    logic r_ptr;

    assign o_winner = (i_req0 && i_req1) ? r_ptr :
                      (i_req1 ? PORT_DBG : PORT_CPU);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= PORT_CPU;
        end else if (i_grant) begin
            r_ptr <= ~o_winner;
        end
    end

`else

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] r_starve;
    logic             w_starved;

    // Once the CPU has won STARVE_LIMIT times in a row over a waiting debug
    // request, the debug port takes the next grant.
    assign w_starved = (r_starve >= CNT_W'(STARVE_LIMIT));
    assign o_winner  = (i_req1 && (!i_req0 || w_starved)) ? PORT_DBG : PORT_CPU;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (i_grant) begin
            if (o_winner == PORT_DBG) begin
                r_starve <= '0;
            end else if (i_req1 && !w_starved) begin
                r_starve <= r_starve + CNT_W'(1);
            end
        end
    end

`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data_mem port between CPU (port 0) and debug/DMA (port 1); one transaction at a time.
// Latency: req seen at cycle 0 -> strobe cycle 1 -> ack cycle 2+MIN_WAIT+stall cycles.
// Backpressure: requests are held until ack; new requests are only looked at in IDLE with stall low.
//
// Ports: pN_req/addr/wdata/write/sign_mask in, pN_ack/pN_rdata out (N=0,1);
//        dm_* drive data_mem, dm_read_data/dm_clk_stall come back; busy, grant_id status.
// Optional macro DMEM_ARB_RR_EN selects round-robin arbitration (see dmem_arbiter_pick).
// MIN_WAIT must be >= 1.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MIN_WAIT     = 1,
    parameter int STARVE_LIMIT = 4
)(
    input  logic              clk,
    input  logic              rst_n,

    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p0_write,
    input  logic [3:0]        p0_sign_mask,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic              p1_write,
    input  logic [3:0]        p1_sign_mask,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,

    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_write_data,
    output logic              dm_memwrite,
    output logic              dm_memread,
    output logic [3:0]        dm_sign_mask,
    input  logic [DATA_W-1:0] dm_read_data,
    input  logic              dm_clk_stall,

    output logic              busy,
    output logic              grant_id
);

    localparam int WCNT_W = $clog2(MIN_WAIT + 1);

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_gid;
    logic               r_write;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [3:0]         r_mask;
    logic [WCNT_W-1:0]  r_wcnt;

    logic               w_winner;
    logic               w_grant;
    logic               w_wait_met;
    logic               w_wait_exit;

    // A stall seen in IDLE belongs to an operation cut short by reset; wait it out
    // so two data_mem operations never overlap.
    assign w_grant     = (r_state == ST_IDLE) && !dm_clk_stall && (p0_req || p1_req);

    // r_wcnt counts WAIT cycles already completed, so the current cycle is number r_wcnt+1.
    assign w_wait_met  = (r_wcnt >= WCNT_W'(MIN_WAIT - 1));
    assign w_wait_exit = (r_state == ST_WAIT) && w_wait_met && !dm_clk_stall;

    dmem_arbiter_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req0   (p0_req),
        .i_req1   (p1_req),
        .i_grant  (w_grant),
        .o_winner (w_winner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        dm_memwrite = 1'b0;
        dm_memread  = 1'b0;
        p0_ack      = 1'b0;
        p1_ack      = 1'b0;
        busy        = (r_state != ST_IDLE);
        grant_id    = (r_state != ST_IDLE) ? r_gid : PORT_CPU;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                dm_memwrite = r_write;
                dm_memread  = ~r_write;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_wait_exit) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                p0_ack      = (r_gid == PORT_CPU);
                p1_ack      = (r_gid == PORT_DBG);
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request latches: loaded only on a grant, so they stay frozen for the whole transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gid   <= PORT_CPU;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_mask  <= '0;
        end else if (w_grant) begin
            r_gid   <= w_winner;
            if (w_winner == PORT_DBG) begin
                r_write <= p1_write;
                r_addr  <= p1_addr;
                r_wdata <= p1_wdata;
                r_mask  <= p1_sign_mask;
            end else begin
                r_write <= p0_write;
                r_addr  <= p0_addr;
                r_wdata <= p0_wdata;
                r_mask  <= p0_sign_mask;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt <= '0;
        end else if (r_state != ST_WAIT) begin
            r_wcnt <= '0;
        end else if (!w_wait_met) begin
            r_wcnt <= r_wcnt + WCNT_W'(1);
        end
    end

    // Load data lands in the requester's register on WAIT exit, so it is visible in the ack cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else if (w_wait_exit && !r_write) begin
            if (r_gid == PORT_DBG) begin
                p1_rdata <= dm_read_data;
            end else begin
                p0_rdata <= dm_read_data;
            end
        end
    end

    assign dm_addr       = r_addr;
    assign dm_write_data = r_wdata;
    assign dm_sign_mask  = r_mask;

endmodule
